// File: rtl/crc_frame_ctrl.sv
// Frame sequencer: parses A5/len/payload RX frames, chains each payload byte
// through an external byte-wide CRC engine and sends the final CRC byte on TX.
module crc_frame_ctrl #(
  parameter logic [7:0] HDR_BYTE     = 8'hA5,
  parameter int         MAX_LEN      = 64,
  parameter logic [7:0] SEED         = 8'h00,
  parameter int         GAP_TIMEOUT  = 100000,
  parameter int         CRC_WAIT_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic [7:0] rx_data,
  input  logic       rx_data_en,
  output logic [7:0] crc_data,
  output logic [7:0] crc_seed,
  output logic       crc_en,
  input  logic [7:0] crc_result,
  input  logic       crc_vld,
  output logic [7:0] tx_data,
  output logic       tx_data_en,
  input  logic       tx_busy,
  output logic       frame_done,
  output logic [2:0] frame_err
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int GW = $clog2(GAP_TIMEOUT + 1);
  localparam int TW = $clog2(CRC_WAIT_MAX + 1);
  localparam logic [7:0]    MAX_N    = 8'(MAX_LEN);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TIMEOUT - 1);
  localparam logic [TW-1:0] CRC_LAST = TW'(CRC_WAIT_MAX);
  localparam int ERR_CRC = 2;
  localparam int ERR_GAP = 1;
  localparam int ERR_LEN = 0;

  typedef enum logic [2:0] {IDLE, LEN, DATA, WAIT_CRC, SEND, WAIT_TX} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    crc_data_n, crc_seed_n, tx_data_n, hold_byte, hold_byte_n;
  logic          crc_en_n, tx_data_en_n, frame_done_n, hold_full, hold_full_n;
  logic [2:0]    frame_err_n;
  logic [GW-1:0] gap_tmr, gap_tmr_n;
  logic [TW-1:0] crc_tmr, crc_tmr_n;
  logic [1:0]    wt_cnt, wt_cnt_n;
  logic          gap_active, gap_to, crc_to;

  assign gap_active = state inside {LEN, DATA, WAIT_CRC};
  assign gap_to     = gap_active && !rx_data_en && (gap_tmr == GAP_LAST);
  assign crc_to     = (state == WAIT_CRC) && !crc_vld && (crc_tmr == CRC_LAST);

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    crc_data_n   = crc_data;
    crc_seed_n   = crc_seed;
    crc_en_n     = 1'b0;
    tx_data_n    = tx_data;
    tx_data_en_n = 1'b0;
    frame_done_n = 1'b0;
    frame_err_n  = frame_err;
    hold_full_n  = hold_full;
    hold_byte_n  = hold_byte;
    wt_cnt_n     = wt_cnt;
    case (state)
      IDLE: if (rx_data_en && rx_data == HDR_BYTE) begin
        frame_err_n = 3'b000;
        state_n     = LEN;
      end
      LEN: begin
        if (rx_data_en) begin
          if (rx_data == 8'd0 || rx_data > MAX_N) begin
            frame_err_n[ERR_LEN] = 1'b1;
            state_n              = IDLE;
          end else begin
            cnt_n       = CW'(rx_data);
            crc_seed_n  = SEED;
            hold_full_n = 1'b0;
            state_n     = DATA;
          end
        end else if (gap_to) begin
          frame_err_n[ERR_GAP] = 1'b1;
          state_n              = IDLE;
        end
      end
      DATA: begin
        if (rx_data_en) begin
          crc_data_n = rx_data;
          crc_en_n   = 1'b1;
          state_n    = WAIT_CRC;
        end else if (gap_to) begin
          frame_err_n[ERR_GAP] = 1'b1;
          state_n              = IDLE;
        end
      end
      WAIT_CRC: begin
        if (crc_vld) begin
          crc_seed_n = crc_result;
          cnt_n      = cnt - 1'b1;
          if (cnt == CNT_ONE) begin
            hold_full_n = 1'b0;
            state_n     = SEND;
          end else if (hold_full) begin
            // held byte goes out now; a byte landing this cycle refills the hold
            crc_data_n  = hold_byte;
            crc_en_n    = 1'b1;
            hold_full_n = rx_data_en;
            hold_byte_n = rx_data_en ? rx_data : hold_byte;
          end else if (rx_data_en) begin
            crc_data_n = rx_data;
            crc_en_n   = 1'b1;
          end else begin
            state_n = DATA;
          end
        end else begin
          if (rx_data_en) begin
            if (hold_full) frame_err_n[ERR_GAP] = 1'b1;
            else begin
              hold_full_n = 1'b1;
              hold_byte_n = rx_data;
            end
          end
          if (crc_to) begin
            frame_err_n[ERR_CRC] = 1'b1;
            hold_full_n          = 1'b0;
            state_n              = IDLE;
          end else if (gap_to) begin
            frame_err_n[ERR_GAP] = 1'b1;
            hold_full_n          = 1'b0;
            state_n              = IDLE;
          end
        end
      end
      SEND: if (!tx_busy) begin
        tx_data_n    = crc_seed;
        tx_data_en_n = 1'b1;
        frame_done_n = 1'b1;
        wt_cnt_n     = 2'd0;
        state_n      = WAIT_TX;
      end
      WAIT_TX: begin
        // uart_send raises busy a couple of cycles late; don't trust it until then
        if (wt_cnt != 2'd2) wt_cnt_n = wt_cnt + 1'b1;
        else if (!tx_busy) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (clear) begin
      state_n      = IDLE;
      crc_seed_n   = SEED;
      frame_err_n  = 3'b000;
      hold_full_n  = 1'b0;
      crc_en_n     = 1'b0;
      tx_data_en_n = 1'b0;
      frame_done_n = 1'b0;
    end
    if (rx_data_en || !gap_active) gap_tmr_n = '0;
    else if (gap_tmr != GAP_LAST)  gap_tmr_n = gap_tmr + 1'b1;
    else                           gap_tmr_n = gap_tmr;
    if (crc_en_n) crc_tmr_n = '0;
    else if (state == WAIT_CRC && crc_tmr != CRC_LAST) crc_tmr_n = crc_tmr + 1'b1;
    else crc_tmr_n = crc_tmr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      crc_data   <= 8'd0;
      crc_seed   <= SEED;
      crc_en     <= 1'b0;
      tx_data    <= 8'd0;
      tx_data_en <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 3'b000;
      hold_full  <= 1'b0;
      hold_byte  <= 8'd0;
      gap_tmr    <= '0;
      crc_tmr    <= '0;
      wt_cnt     <= 2'd0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      crc_data   <= crc_data_n;
      crc_seed   <= crc_seed_n;
      crc_en     <= crc_en_n;
      tx_data    <= tx_data_n;
      tx_data_en <= tx_data_en_n;
      frame_done <= frame_done_n;
      frame_err  <= frame_err_n;
      hold_full  <= hold_full_n;
      hold_byte  <= hold_byte_n;
      gap_tmr    <= gap_tmr_n;
      crc_tmr    <= crc_tmr_n;
      wt_cnt     <= wt_cnt_n;
    end
  end

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Bench for crc_frame_ctrl: CRC-8 engine and UART responders plus a payload-level
// reference (fold of CRC over the frame bytes from the seed).
module tb_crc_frame_ctrl;
  localparam logic [7:0] HDR   = 8'hA5;
  localparam int         MAXL  = 64;
  localparam logic [7:0] SEEDV = 8'h3C;
  localparam int         GAP_T = 300;
  localparam int         CWM   = 16;
  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0, rst = 1'b1, clear = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_data_en = 1'b0;
  logic [7:0] crc_data, crc_seed, tx_data;
  logic       crc_en, tx_data_en, frame_done;
  logic [2:0] frame_err;
  logic [7:0] crc_result = 8'd0;
  logic       crc_vld = 1'b0, tx_busy = 1'b0;

  crc_frame_ctrl #(.HDR_BYTE(HDR), .MAX_LEN(MAXL), .SEED(SEEDV),
                   .GAP_TIMEOUT(GAP_T), .CRC_WAIT_MAX(CWM)) dut (
    .clk(clk), .rst(rst), .clear(clear), .rx_data(rx_data), .rx_data_en(rx_data_en),
    .crc_data(crc_data), .crc_seed(crc_seed), .crc_en(crc_en),
    .crc_result(crc_result), .crc_vld(crc_vld), .tx_data(tx_data),
    .tx_data_en(tx_data_en), .tx_busy(tx_busy), .frame_done(frame_done),
    .frame_err(frame_err));

  initial forever #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0;
  int crc_lat = 2, done_cnt = 0;
  bit crc_mute = 0, force_busy = 0, clr_on_vld = 0;
  bq_t en_data, en_seed, tx_q;
  int en_cyc[$], vld_cyc[$];

  function automatic logic [7:0] crc_f(input logic [7:0] d, input logic [7:0] s);
    logic [7:0] c;
    c = d ^ s;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction

  function automatic logic [7:0] crc_fold(input bq_t p);
    logic [7:0] s;
    s = SEEDV;
    foreach (p[i]) s = crc_f(p[i], s);
    return s;
  endfunction

  initial forever @(posedge clk) cyc++;

  // crc engine + uart_send models; also issues the clear pulse on request
  initial begin
    int pend, uart_cnt;
    logic [7:0] pend_res;
    pend = 0; uart_cnt = 0; pend_res = 8'd0;
    forever begin
      @(posedge clk); #1;
      crc_vld = 1'b0; clear = 1'b0;
      if (uart_cnt > 0) uart_cnt--;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          crc_vld = 1'b1; crc_result = pend_res; vld_cyc.push_back(cyc);
          if (clr_on_vld) begin clear = 1'b1; clr_on_vld = 0; end
        end
      end
      if (crc_en && !crc_mute) begin pend = crc_lat; pend_res = crc_f(crc_data, crc_seed); end
      if (tx_data_en) uart_cnt = 10;
      if (rst) begin pend = 0; uart_cnt = 0; end
      tx_busy = force_busy || (uart_cnt > 0);
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (crc_en) begin en_data.push_back(crc_data); en_seed.push_back(crc_seed); en_cyc.push_back(cyc); end
    if (tx_data_en) tx_q.push_back(tx_data);
    if (frame_done) done_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic clr_mon();
    en_data.delete(); en_seed.delete(); tx_q.delete(); en_cyc.delete(); vld_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_data_en = 1'b1; tick(); rx_data_en = 1'b0;
  endtask

  task automatic send_frame(input bq_t p, input int gmin, input int gmax);
    send_byte(HDR); repeat ($urandom_range(gmin, gmax)) tick();
    send_byte(8'(p.size())); repeat ($urandom_range(gmin, gmax)) tick();
    foreach (p[i]) begin send_byte(p[i]); repeat ($urandom_range(gmin, gmax)) tick(); end
  endtask

  task automatic wait_tx(input int n, input int budget);
    int k;
    k = 0;
    while (tx_q.size() < n && k < budget) begin tick(); k++; end
  endtask

  task automatic test_reset();
    tests++; if (crc_seed !== SEEDV) begin fails++; $display("FAIL reset crc_seed got %h want %h", crc_seed, SEEDV); end
    tests++; if ({crc_en, tx_data_en, frame_done} !== 3'b000) begin fails++; $display("FAIL reset strobes got %b want 000", {crc_en, tx_data_en, frame_done}); end
    tests++; if ({crc_data, tx_data} !== 16'h0) begin fails++; $display("FAIL reset data got %h want 0000", {crc_data, tx_data}); end
    tests++; if (frame_err !== 3'b000) begin fails++; $display("FAIL reset frame_err got %b want 000", frame_err); end
  endtask

  task automatic test_basic();
    for (int f = 0; f < 9; f++) begin
      bq_t p;
      int n;
      logic [7:0] s;
      p.delete();
      if (f == 0) p = {8'h11, 8'h22, 8'h33};
      else begin
        n = (f == 1) ? 1 : (f == 2) ? MAXL : int'($urandom_range(2, 20));
        for (int i = 0; i < n; i++) p.push_back(8'($urandom));
      end
      crc_lat = (f == 0) ? 2 : int'($urandom_range(1, 4));
      clr_mon();
      send_frame(p, crc_lat, crc_lat + 3);
      wait_tx(1, 100); repeat (15) tick();
      tests++; if (en_data.size() != p.size()) begin fails++; $display("FAIL basic f%0d crc_en count got %0d want %0d", f, en_data.size(), p.size()); end
      s = SEEDV;
      for (int i = 0; i < p.size() && i < en_data.size(); i++) begin
        tests++; if (en_data[i] !== p[i] || en_seed[i] !== s) begin
          fails++; $display("FAIL basic f%0d byte%0d data/seed got %h/%h want %h/%h", f, i, en_data[i], en_seed[i], p[i], s);
        end
        s = crc_f(p[i], s);
      end
      tests++; if (tx_q.size() != 1 || tx_q[0] !== crc_fold(p)) begin fails++; $display("FAIL basic f%0d tx count/byte got %0d/%h want 1/%h", f, tx_q.size(), tx_q[0], crc_fold(p)); end
      tests++; if (done_cnt != 1 || frame_err !== 3'b000) begin fails++; $display("FAIL basic f%0d done/err got %0d/%b want 1/000", f, done_cnt, frame_err); end
    end
  endtask

  task automatic test_bad_len();
    crc_lat = 2; clr_mon();
    send_byte(8'h11); send_byte(8'h03); tick();
    send_byte(HDR); send_byte(8'h00); tick();
    tests++; if (frame_err !== 3'b001) begin fails++; $display("FAIL badlen N=0 err got %b want 001", frame_err); end
    send_byte(HDR); send_byte(8'(MAXL + 1)); tick();
    tests++; if (frame_err !== 3'b001) begin fails++; $display("FAIL badlen N=65 err got %b want 001", frame_err); end
    send_byte(8'h05); send_byte(8'h06); repeat (5) tick();
    tests++; if (en_data.size() != 0) begin fails++; $display("FAIL badlen crc_en count got %0d want 0", en_data.size()); end
    send_byte(HDR); tick();
    tests++; if (frame_err !== 3'b000) begin fails++; $display("FAIL badlen header clear err got %b want 000", frame_err); end
    send_byte(8'h01); send_byte(8'h77); wait_tx(1, 60); repeat (15) tick();
    tests++; if (tx_q.size() != 1 || tx_q[0] !== crc_f(8'h77, SEEDV)) begin fails++; $display("FAIL badlen recovery tx got %0d/%h want 1/%h", tx_q.size(), tx_q[0], crc_f(8'h77, SEEDV)); end
  endtask

  task automatic test_gap();
    crc_lat = 2; clr_mon();
    send_byte(HDR); send_byte(8'h02); send_byte(8'h10);
    repeat (GAP_T - 20) tick();
    tests++; if (frame_err !== 3'b000) begin fails++; $display("FAIL gap early err got %b want 000", frame_err); end
    repeat (40) tick();
    tests++; if (frame_err !== 3'b010) begin fails++; $display("FAIL gap timeout err got %b want 010", frame_err); end
    send_byte(8'h20); send_byte(8'h30); repeat (10) tick();
    tests++; if (en_data.size() != 1 || tx_q.size() != 0 || done_cnt != 0) begin
      fails++; $display("FAIL gap after-exit en/tx/done got %0d/%0d/%0d want 1/0/0", en_data.size(), tx_q.size(), done_cnt);
    end
  endtask

  task automatic test_hold();
    logic [7:0] b1, b2, b3, b4;
    b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom); b4 = 8'($urandom);
    crc_lat = 5; clr_mon();
    send_byte(HDR); send_byte(8'h02); tick();
    send_byte(b1); tick(); send_byte(b2);
    wait_tx(1, 100); repeat (15) tick();
    tests++; if (en_data.size() != 2 || en_data[1] !== b2 || en_seed[1] !== crc_f(b1, SEEDV)) begin
      fails++; $display("FAIL hold held byte count/data/seed got %0d/%h/%h want 2/%h/%h", en_data.size(), en_data[1], en_seed[1], b2, crc_f(b1, SEEDV));
    end
    tests++; if (vld_cyc.size() < 1 || en_cyc[1] != vld_cyc[0] + 1) begin fails++; $display("FAIL hold issue cycle got %0d want %0d", en_cyc[1], vld_cyc[0] + 1); end
    tests++; if (tx_q.size() != 1 || tx_q[0] !== crc_fold({b1, b2}) || frame_err !== 3'b000) begin
      fails++; $display("FAIL hold tx/err got %h/%b want %h/000", tx_q[0], frame_err, crc_fold({b1, b2}));
    end
    clr_mon();
    send_byte(HDR); send_byte(8'h03); tick();
    send_byte(b1); tick(); send_byte(b2); send_byte(b3); tick();
    tests++; if (frame_err !== 3'b010) begin fails++; $display("FAIL overrun err got %b want 010", frame_err); end
    repeat (20) tick(); send_byte(b4);
    wait_tx(1, 100); repeat (15) tick();
    tests++; if (en_data.size() != 3 || en_data[2] !== b4) begin fails++; $display("FAIL overrun crc_en count/last got %0d/%h want 3/%h", en_data.size(), en_data[2], b4); end
    tests++; if (tx_q.size() != 1 || tx_q[0] !== crc_fold({b1, b2, b4}) || frame_err !== 3'b010) begin
      fails++; $display("FAIL overrun tx/err got %h/%b want %h/010", tx_q[0], frame_err, crc_fold({b1, b2, b4}));
    end
  endtask

  task automatic test_crc_timeout();
    crc_lat = CWM; clr_mon();
    send_frame({8'h5A}, 0, 0); wait_tx(1, 60); repeat (15) tick();
    tests++; if (tx_q.size() != 1 || frame_err !== 3'b000) begin fails++; $display("FAIL crcwait max latency tx/err got %0d/%b want 1/000", tx_q.size(), frame_err); end
    crc_lat = CWM + 1; clr_mon();
    send_frame({8'h5B}, 0, 0); repeat (40) tick();
    tests++; if (frame_err !== 3'b100 || tx_q.size() != 0 || done_cnt != 0) begin
      fails++; $display("FAIL crc timeout err/tx/done got %b/%0d/%0d want 100/0/0", frame_err, tx_q.size(), done_cnt);
    end
    tests++; if (crc_seed !== SEEDV) begin fails++; $display("FAIL late crc_vld seed got %h want %h", crc_seed, SEEDV); end
  endtask

  task automatic test_back_to_back();
    bq_t p;
    p.delete();
    for (int i = 0; i < 3; i++) p.push_back(8'($urandom));
    crc_lat = 2; force_busy = 1; clr_mon();
    send_frame(p, 2, 3); repeat (200) tick();
    tests++; if (tx_q.size() != 0) begin fails++; $display("FAIL busy tx while busy got %0d want 0", tx_q.size()); end
    force_busy = 0; wait_tx(1, 30); repeat (20) tick();
    tests++; if (tx_q.size() != 1 || tx_q[0] !== crc_fold(p) || done_cnt != 1) begin
      fails++; $display("FAIL busy release tx/byte/done got %0d/%h/%0d want 1/%h/1", tx_q.size(), tx_q[0], done_cnt, crc_fold(p));
    end
    for (int f = 0; f < 2; f++) begin
      p.delete();
      for (int i = 0; i < 4; i++) p.push_back(8'($urandom));
      clr_mon(); send_frame(p, 2, 2); wait_tx(1, 60); repeat (15) tick();
      tests++; if (en_seed.size() != 4 || en_seed[0] !== SEEDV || tx_q.size() != 1 || tx_q[0] !== crc_fold(p)) begin
        fails++; $display("FAIL b2b f%0d seed0/tx got %h/%h want %h/%h", f, en_seed[0], tx_q[0], SEEDV, crc_fold(p));
      end
    end
  endtask

  task automatic test_abort();
    crc_lat = 3; clr_mon();
    send_byte(HDR); send_byte(8'h03); tick();
    clr_on_vld = 1;
    send_byte(8'h61); tick(); send_byte(8'h62); send_byte(8'h63);
    repeat (30) tick();
    tests++; if (crc_seed !== SEEDV || frame_err !== 3'b000) begin fails++; $display("FAIL clear seed/err got %h/%b want %h/000", crc_seed, frame_err, SEEDV); end
    send_byte(8'h44); repeat (10) tick();
    tests++; if (en_data.size() != 1 || tx_q.size() != 0) begin fails++; $display("FAIL clear en/tx after got %0d/%0d want 1/0", en_data.size(), tx_q.size()); end
    crc_lat = 2; clr_mon();
    send_byte(HDR); send_byte(8'h03); send_byte(8'h71); repeat (6) tick();
    rst = 1'b1; tick(); rst = 1'b0; tick();
    tests++; if (crc_seed !== SEEDV || frame_err !== 3'b000 || crc_en !== 1'b0) begin
      fails++; $display("FAIL rst seed/err/en got %h/%b/%b want %h/000/0", crc_seed, frame_err, crc_en, SEEDV);
    end
    send_byte(8'h55); send_byte(8'h66); repeat (20) tick();
    tests++; if (en_data.size() != 1 || tx_q.size() != 0) begin fails++; $display("FAIL rst en/tx after got %0d/%0d want 1/0", en_data.size(), tx_q.size()); end
  endtask

  initial begin
    rst = 1'b1; repeat (3) tick();
    test_reset();
    rst = 1'b0; tick();
    test_basic();
    test_bad_len();
    test_gap();
    test_hold();
    test_crc_timeout();
    test_back_to_back();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
